// File: rtl/hazard_stall_unit.sv
// Pipeline hazard/stall controller for the hazards forwarding cannot cover:
// load-use bubbles, data-memory wait freezes and taken-branch flushes.
// Also runs a memory-wait timeout FSM and a saturating stall-cycle counter.
//
// state  | meaning
// -------+-----------------------------------------------------------
// S_RUN  | no outstanding memory wait
// S_WAIT | data memory busy; wait_cnt counts consecutive busy cycles
// S_ERR  | wait exceeded MEM_TIMEOUT; pipeline frozen until rst_n
module hazard_stall_unit #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ID_rs1,
  input  logic [4:0]       ID_rs2,
  input  logic             ID_uses_rs1,
  input  logic             ID_uses_rs2,
  input  logic             EX_MemRead,
  input  logic [4:0]       EX_RegWriteAddr,
  input  logic             EX_BranchTaken,
  input  logic             MEM_MemAccess,
  input  logic             mem_ready,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam int unsigned WCW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] TIMEOUT_VAL = WCW'(MEM_TIMEOUT);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  state_t         state, state_nxt;
  logic [WCW-1:0] wait_cnt, wait_cnt_nxt;

  logic load_use;
  logic mem_busy;
  logic freeze;
  logic any_ctl;

  // Hazard detection; x0 is never a real dependency.
  assign load_use = EX_MemRead && (EX_RegWriteAddr != 5'd0) &&
                    ((ID_uses_rs1 && (ID_rs1 == EX_RegWriteAddr)) ||
                     (ID_uses_rs2 && (ID_rs2 == EX_RegWriteAddr)));
  assign mem_busy = MEM_MemAccess && !mem_ready;
  assign freeze   = mem_busy || (state == S_ERR);

  // State and wait-length counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // Next-state logic for the memory-wait timeout tracker.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    case (state)
      S_RUN: begin
        if (mem_busy) begin
          state_nxt    = S_WAIT;
          wait_cnt_nxt = WCW'(1);
        end else begin
          wait_cnt_nxt = '0;
        end
      end
      S_WAIT: begin
        if (!mem_busy) begin
          state_nxt    = S_RUN;
          wait_cnt_nxt = '0;
        end else if (wait_cnt == TIMEOUT_VAL) begin
          state_nxt = S_ERR;
        end else begin
          wait_cnt_nxt = wait_cnt + WCW'(1);
        end
      end
      S_ERR: begin
        state_nxt = S_ERR;
      end
      default: begin
        state_nxt    = S_RUN;
        wait_cnt_nxt = '0;
      end
    endcase
  end

  // Pipeline control, zero latency. A frozen pipeline keeps branch/load-use
  // inputs stable, so those actions are simply deferred until the freeze ends.
  always_comb begin
    pc_hold     = 1'b0;
    ifid_hold   = 1'b0;
    idex_hold   = 1'b0;
    exmem_hold  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    if (freeze) begin
      pc_hold    = 1'b1;
      ifid_hold  = 1'b1;
      idex_hold  = 1'b1;
      exmem_hold = 1'b1;
    end else if (EX_BranchTaken) begin
      ifid_flush  = 1'b1;
      idex_bubble = 1'b1;
    end else if (load_use) begin
      pc_hold     = 1'b1;
      ifid_hold   = 1'b1;
      idex_bubble = 1'b1;
    end
  end

  assign any_ctl = pc_hold | ifid_hold | idex_hold | exmem_hold |
                   idex_bubble | ifid_flush;

  // Sticky timeout flag and saturating stall counter (frozen once in S_ERR).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
    end else begin
      mem_timeout <= (state_nxt == S_ERR);
      if (any_ctl && (state != S_ERR) && (stall_cycles != {CNT_W{1'b1}})) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Directed bench for hazard_stall_unit: a default-parameter instance (a_*)
// and a small one (b_*, MEM_TIMEOUT=4, CNT_W=4) share all inputs.
module tb_hazard_stall_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic [4:0] ID_rs1, ID_rs2, EX_RegWriteAddr;
  logic       ID_uses_rs1, ID_uses_rs2, EX_MemRead, EX_BranchTaken;
  logic       MEM_MemAccess, mem_ready;

  logic        a_pc_hold, a_ifid_hold, a_idex_hold, a_exmem_hold;
  logic        a_idex_bubble, a_ifid_flush, a_to;
  logic [31:0] a_stall;
  logic        b_pc_hold, b_ifid_hold, b_idex_hold, b_exmem_hold;
  logic        b_idex_bubble, b_ifid_flush, b_to;
  logic [3:0]  b_stall;

  logic [5:0] a_ctl, b_ctl;
  assign a_ctl = {a_pc_hold, a_ifid_hold, a_idex_hold, a_exmem_hold, a_idex_bubble, a_ifid_flush};
  assign b_ctl = {b_pc_hold, b_ifid_hold, b_idex_hold, b_exmem_hold, b_idex_bubble, b_ifid_flush};

  localparam logic [5:0] CTL_NONE   = 6'b000000;
  localparam logic [5:0] CTL_LU     = 6'b110010;
  localparam logic [5:0] CTL_FREEZE = 6'b111100;
  localparam logic [5:0] CTL_FLUSH  = 6'b000011;

  int tests_run = 0;
  int tests_failed = 0;

  hazard_stall_unit u_a (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .EX_MemRead(EX_MemRead),
    .EX_RegWriteAddr(EX_RegWriteAddr), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .mem_ready(mem_ready),
    .pc_hold(a_pc_hold), .ifid_hold(a_ifid_hold), .idex_hold(a_idex_hold),
    .exmem_hold(a_exmem_hold), .idex_bubble(a_idex_bubble), .ifid_flush(a_ifid_flush),
    .mem_timeout(a_to), .stall_cycles(a_stall)
  );

  hazard_stall_unit #(.MEM_TIMEOUT(4), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .ID_rs1(ID_rs1), .ID_rs2(ID_rs2),
    .ID_uses_rs1(ID_uses_rs1), .ID_uses_rs2(ID_uses_rs2), .EX_MemRead(EX_MemRead),
    .EX_RegWriteAddr(EX_RegWriteAddr), .EX_BranchTaken(EX_BranchTaken),
    .MEM_MemAccess(MEM_MemAccess), .mem_ready(mem_ready),
    .pc_hold(b_pc_hold), .ifid_hold(b_ifid_hold), .idex_hold(b_idex_hold),
    .exmem_hold(b_exmem_hold), .idex_bubble(b_idex_bubble), .ifid_flush(b_ifid_flush),
    .mem_timeout(b_to), .stall_cycles(b_stall)
  );

  typedef struct {
    bit       rd;
    bit [4:0] wa;
    bit [4:0] rs1;
    bit [4:0] rs2;
    bit       u1;
    bit       u2;
    bit       exp;
  } lu_vec_t;

  lu_vec_t lu_vecs [6];

  task automatic idle();
    ID_rs1 = 5'd0; ID_rs2 = 5'd0; ID_uses_rs1 = 1'b0; ID_uses_rs2 = 1'b0;
    EX_MemRead = 1'b0; EX_RegWriteAddr = 5'd0; EX_BranchTaken = 1'b0;
    MEM_MemAccess = 1'b0; mem_ready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    step();
    idle();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
  endtask

  task automatic set_load_use(input logic [4:0] r);
    EX_MemRead = 1'b1; EX_RegWriteAddr = r; ID_rs1 = r; ID_uses_rs1 = 1'b1;
  endtask

  task automatic test_reset();
    step();
    idle();
    mem_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    tests_run++;
    if (a_ctl !== CTL_NONE || b_ctl !== CTL_NONE) begin
      tests_failed++;
      $display("FAIL reset_ctl: a=%b b=%b expected 000000", a_ctl, b_ctl);
    end
    step();
    rst_n = 1'b1;
    step();
    step();
    tests_run++;
    if (a_ctl !== CTL_NONE || a_stall !== 32'd0 || a_to !== 1'b0 || b_stall !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_idle: ctl=%b stall=%0d to=%b b_stall=%0d expected 0/0/0/0",
               a_ctl, a_stall, a_to, b_stall);
    end
    mem_ready = 1'b0;
  endtask

  task automatic test_load_use();
    int exp_cnt;
    lu_vecs[0] = '{rd: 1'b1, wa: 5'd5,  rs1: 5'd5,  rs2: 5'd0, u1: 1'b1, u2: 1'b0, exp: 1'b1};
    lu_vecs[1] = '{rd: 1'b1, wa: 5'd5,  rs1: 5'd7,  rs2: 5'd5, u1: 1'b0, u2: 1'b1, exp: 1'b1};
    lu_vecs[2] = '{rd: 1'b1, wa: 5'd5,  rs1: 5'd7,  rs2: 5'd5, u1: 1'b1, u2: 1'b0, exp: 1'b0};
    lu_vecs[3] = '{rd: 1'b1, wa: 5'd0,  rs1: 5'd0,  rs2: 5'd0, u1: 1'b1, u2: 1'b1, exp: 1'b0};
    lu_vecs[4] = '{rd: 1'b0, wa: 5'd5,  rs1: 5'd5,  rs2: 5'd5, u1: 1'b1, u2: 1'b1, exp: 1'b0};
    lu_vecs[5] = '{rd: 1'b1, wa: 5'd31, rs1: 5'd31, rs2: 5'd3, u1: 1'b1, u2: 1'b1, exp: 1'b1};
    do_reset();
    exp_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      EX_MemRead = lu_vecs[i].rd; EX_RegWriteAddr = lu_vecs[i].wa;
      ID_rs1 = lu_vecs[i].rs1; ID_rs2 = lu_vecs[i].rs2;
      ID_uses_rs1 = lu_vecs[i].u1; ID_uses_rs2 = lu_vecs[i].u2;
      #1;
      tests_run++;
      if (a_ctl !== (lu_vecs[i].exp ? CTL_LU : CTL_NONE)) begin
        tests_failed++;
        $display("FAIL load_use_ctl[%0d]: got %b expected %b", i, a_ctl,
                 lu_vecs[i].exp ? CTL_LU : CTL_NONE);
      end
      if (lu_vecs[i].exp) exp_cnt++;
      step();
      tests_run++;
      if (a_stall !== 32'(exp_cnt)) begin
        tests_failed++;
        $display("FAIL load_use_cnt[%0d]: got %0d expected %0d", i, a_stall, exp_cnt);
      end
    end
    idle();
  endtask

  task automatic test_branch();
    do_reset();
    set_load_use(5'd5);
    EX_BranchTaken = 1'b1;
    #1;
    tests_run++;
    if (a_ctl !== CTL_FLUSH) begin
      tests_failed++;
      $display("FAIL branch_over_load_use: got %b expected %b", a_ctl, CTL_FLUSH);
    end
    step();
    idle();
    EX_BranchTaken = 1'b1;
    #1;
    tests_run++;
    if (a_ctl !== CTL_FLUSH) begin
      tests_failed++;
      $display("FAIL branch_alone: got %b expected %b", a_ctl, CTL_FLUSH);
    end
    step();
    idle();
    tests_run++;
    if (a_stall !== 32'd2) begin
      tests_failed++;
      $display("FAIL branch_cnt: got %0d expected 2", a_stall);
    end
  endtask

  task automatic test_mem_wait();
    do_reset();
    for (int burst = 0; burst < 2; burst++) begin
      MEM_MemAccess = 1'b1;
      mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
        #1;
        tests_run++;
        if (a_ctl !== CTL_FREEZE) begin
          tests_failed++;
          $display("FAIL mem_wait_freeze[%0d.%0d]: got %b expected %b", burst, i, a_ctl, CTL_FREEZE);
        end
        step();
      end
      mem_ready = 1'b1;
      #1;
      tests_run++;
      if (a_ctl !== CTL_NONE) begin
        tests_failed++;
        $display("FAIL mem_wait_release[%0d]: got %b expected 000000", burst, a_ctl);
      end
      step();
      idle();
      if (burst == 0) begin
        tests_run++;
        if (a_stall !== 32'd3 || a_to !== 1'b0) begin
          tests_failed++;
          $display("FAIL mem_wait_cnt: stall=%0d to=%b expected 3/0", a_stall, a_to);
        end
      end
    end
    tests_run++;
    if (b_to !== 1'b0 || b_stall !== 4'd6) begin
      tests_failed++;
      $display("FAIL mem_wait_back_to_run: b_to=%b b_stall=%0d expected 0/6", b_to, b_stall);
    end
  endtask

  task automatic test_freeze_priority();
    do_reset();
    set_load_use(5'd9);
    EX_BranchTaken = 1'b1;
    MEM_MemAccess = 1'b1;
    mem_ready = 1'b0;
    #1;
    tests_run++;
    if (a_ctl !== CTL_FREEZE) begin
      tests_failed++;
      $display("FAIL freeze_priority: got %b expected %b", a_ctl, CTL_FREEZE);
    end
    step();
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if (a_ctl !== CTL_FLUSH) begin
      tests_failed++;
      $display("FAIL deferred_flush: got %b expected %b", a_ctl, CTL_FLUSH);
    end
    step();
    idle();
    tests_run++;
    if (a_stall !== 32'd2) begin
      tests_failed++;
      $display("FAIL freeze_priority_cnt: got %0d expected 2", a_stall);
    end
  endtask

  task automatic test_timeout_small();
    do_reset();
    MEM_MemAccess = 1'b1;
    mem_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      step();
      tests_run++;
      if (b_to !== (k >= 5) || b_ctl !== CTL_FREEZE) begin
        tests_failed++;
        $display("FAIL timeout_small[%0d]: to=%b ctl=%b expected %b/%b", k, b_to, b_ctl,
                 (k >= 5), CTL_FREEZE);
      end
    end
    mem_ready = 1'b1;
    #1;
    tests_run++;
    if (b_ctl !== CTL_FREEZE || a_ctl !== CTL_NONE || a_to !== 1'b0) begin
      tests_failed++;
      $display("FAIL err_freeze: b_ctl=%b a_ctl=%b a_to=%b expected %b/000000/0",
               b_ctl, a_ctl, a_to, CTL_FREEZE);
    end
    step();
    step();
    tests_run++;
    if (b_stall !== 4'd5 || b_to !== 1'b1) begin
      tests_failed++;
      $display("FAIL err_cnt_stop: stall=%0d to=%b expected 5/1", b_stall, b_to);
    end
    rst_n = 1'b0;
    idle();
    #1;
    tests_run++;
    if (b_to !== 1'b0 || b_stall !== 4'd0 || b_ctl !== CTL_NONE) begin
      tests_failed++;
      $display("FAIL err_reset: to=%b stall=%0d ctl=%b expected 0/0/000000", b_to, b_stall, b_ctl);
    end
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_timeout_default();
    do_reset();
    MEM_MemAccess = 1'b1;
    mem_ready = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      step();
      if (k >= 15) begin
        tests_run++;
        if (a_to !== (k >= 17)) begin
          tests_failed++;
          $display("FAIL timeout_default[%0d]: got %b expected %b", k, a_to, (k >= 17));
        end
      end
    end
    tests_run++;
    if (a_stall !== 32'd17) begin
      tests_failed++;
      $display("FAIL timeout_default_cnt: got %0d expected 17", a_stall);
    end
    idle();
  endtask

  task automatic test_saturate();
    do_reset();
    set_load_use(5'd12);
    for (int k = 1; k <= 20; k++) begin
      step();
      if (k == 14) begin
        tests_run++;
        if (b_stall !== 4'd14) begin
          tests_failed++;
          $display("FAIL saturate_pre: got %0d expected 14", b_stall);
        end
      end
    end
    tests_run++;
    if (b_stall !== 4'd15 || a_stall !== 32'd20) begin
      tests_failed++;
      $display("FAIL saturate: b=%0d a=%0d expected 15/20", b_stall, a_stall);
    end
    idle();
  endtask

  initial begin
    rst_n = 1'b1;
    idle();
    test_reset();
    test_load_use();
    test_branch();
    test_mem_wait();
    test_freeze_priority();
    test_timeout_small();
    test_timeout_default();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
